// File: rtl/t07_mem_pkg.sv
// Shared types and constants for the team 07 memory arbiter.
package t07_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_WRITE = 2'b01;
  localparam logic [1:0] RWI_READ  = 2'b10;
  localparam logic [1:0] RWI_FETCH = 2'b11;

  localparam logic [31:0] DEADBEEF_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/t07_falling_edge_det.sv
// Registers the previous value of a level signal and flags its high-to-low transition.
module t07_falling_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic sig,
  output logic fall
);

  logic sig_prev_q;
  logic sig_prev_d;

  always_comb begin
    sig_prev_d = sig;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sig_prev_q <= 1'b0;
    end else begin
      sig_prev_q <= sig_prev_d;
    end
  end

  assign fall = sig_prev_q & ~sig;

endmodule

// File: rtl/t07_mem_arbiter.sv
// Shares the single memory/MMIO port between fetch and data traffic, data first,
// with a burst limit that guarantees fetch progress and a WAIT timeout.
module t07_mem_arbiter
  import t07_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        grant_d,
  output logic        arb_busy,
  output logic [1:0]  mem_rwi,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);
  localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT_CYCLES);

  arb_state_t  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  mem_rwi_q, mem_rwi_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic        grant_d_q, grant_d_d;
  logic        arb_busy_q, arb_busy_d;

  logic busy_fall;
  logic tmo_hit;
  logic grant_data;
  logic grant_fetch;

  t07_falling_edge_det u_busy_edge (
    .clk  (clk),
    .nrst (nrst),
    .sig  (mem_busy),
    .fall (busy_fall)
  );

  assign tmo_hit = (tmo_cnt_q + 8'd1) == TMO_LIMIT;

  // Data wins unless fetch is waiting and data has used up its burst allowance.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && (!if_req || (streak_q < BURST_LIMIT))) begin
        grant_data = 1'b1;
      end else if (if_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_data || grant_fetch) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (busy_fall || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A completion edge takes precedence over a timeout landing in the same cycle.
  always_comb begin
    streak_d    = streak_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_rwi_d   = mem_rwi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d_d   = grant_d_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    arb_busy_d  = (state_d != IDLE);

    if (grant_data) begin
      grant_d_d   = 1'b1;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_rwi_d   = d_we ? RWI_WRITE : RWI_READ;
      streak_d    = (streak_q < BURST_LIMIT) ? streak_q + 4'd1 : streak_q;
    end else if (grant_fetch) begin
      grant_d_d  = 1'b0;
      mem_addr_d = if_addr;
      mem_rwi_d  = RWI_FETCH;
      streak_d   = 4'd0;
    end

    if (state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
      if (busy_fall || tmo_hit) begin
        mem_rwi_d = RWI_IDLE;
        err_d     = !busy_fall;
        if (grant_d_q) begin
          d_done_d = 1'b1;
        end else begin
          if_done_d = 1'b1;
        end
        if (mem_rwi_q != RWI_WRITE) begin
          if (grant_d_q) begin
            d_rdata_d = busy_fall ? mem_rdata : DEADBEEF_WORD;
          end else begin
            if_rdata_d = busy_fall ? mem_rdata : DEADBEEF_WORD;
          end
        end
      end
    end

    if (state_q == DONE) begin
      tmo_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      streak_q    <= 4'd0;
      tmo_cnt_q   <= 8'd0;
      mem_rwi_q   <= RWI_IDLE;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      grant_d_q   <= 1'b0;
      arb_busy_q  <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_rwi_q   <= mem_rwi_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      grant_d_q   <= grant_d_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

  assign mem_rwi   = mem_rwi_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign grant_d   = grant_d_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Scoreboard bench for t07_mem_arbiter: directed transactions push expected completions,
// a negedge monitor pops and checks them whenever a done pulse appears.
module tb_t07_mem_arbiter;
  import t07_mem_pkg::*;

  typedef struct {
    logic        is_data;
    logic        store;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        grant_d;
  logic        arb_busy;
  logic [1:0]  mem_rwi;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata = 32'd0;
  logic [31:0] mon_owner;
  bit          burst_is_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  t07_mem_arbiter #(
    .MAX_DATA_BURST (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .err       (err),
    .grant_d   (grant_d),
    .arb_busy  (arb_busy),
    .mem_rwi   (mem_rwi),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ia, input logic dr,
                               input logic we, input logic [31:0] da, input logic [31:0] wd);
    if_req  = ifr;
    if_addr = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
  endtask

  task automatic pushExp(input logic is_data, input logic store, input logic [31:0] rdata,
                         input logic e, input int c);
    exp_t x;
    x.is_data = is_data;
    x.store   = store;
    x.rdata   = rdata;
    x.err     = e;
    x.cyc     = c;
    sb.push_back(x);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_mem_rwi"}, 32'(mem_rwi), 32'(RWI_IDLE));
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_if_rdata"}, if_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, "_if_done"}, 32'(if_done), 32'd0);
    checkOutput({tag, "_d_done"}, 32'(d_done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_grant_d"}, 32'(grant_d), 32'd0);
    checkOutput({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (nrst && (if_done || d_done)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got if_done=%b d_done=%b, required no done (cycle %0d)",
                 if_done, d_done, cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_owner = mon_e.store ? exp_d_rdata : mon_e.rdata;
        checkOutput("done_kind", {30'd0, if_done, d_done}, mon_e.is_data ? 32'd1 : 32'd2);
        checkOutput("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        checkOutput("done_err", 32'(err), 32'(mon_e.err));
        if (mon_e.is_data) begin
          checkOutput("done_d_rdata", d_rdata, mon_owner);
          checkOutput("hold_if_rdata", if_rdata, exp_if_rdata);
          exp_d_rdata = mon_owner;
        end else begin
          checkOutput("done_if_rdata", if_rdata, mon_owner);
          checkOutput("hold_d_rdata", d_rdata, exp_d_rdata);
          exp_if_rdata = mon_owner;
        end
      end
    end
  end

  initial begin
    #20000;
    bad++;
    total++;
    $display("[TB] FAIL watchdog: got no end of test, required completion before 20000 ns");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int w;
    nrst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_busy  = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) step();
    checkReset("rst");
    nrst = 1'b1;
    step();

    // Fetch alone: busy high cycles 2..5, falls in 6, done in 7.
    step();
    t0 = cyc;
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 32'd0);
    pushExp(1'b0, 1'b0, 32'h1234_5678, 1'b0, t0 + 7);
    step();
    checkOutput("t1_rwi_c1", 32'(mem_rwi), 32'(RWI_FETCH));
    checkOutput("t1_addr", mem_addr, 32'h0000_0040);
    for (int c = 2; c <= 6; c++) begin
      step();
      mem_busy = (c <= 5);
      if (c == 6) mem_rdata = 32'h1234_5678;
      checkOutput("t1_rwi_wait", 32'(mem_rwi), 32'(RWI_FETCH));
    end
    step();
    checkOutput("t1_rwi_done", 32'(mem_rwi), 32'(RWI_IDLE));
    step();
    if_req = 1'b0;
    checkOutput("t1_idle", 32'(arb_busy), 32'd0);

    // Store: busy pulses in cycles 2..3, falls in 4, done in 5; d_rdata untouched.
    step();
    t0 = cyc;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0004, 32'hCAFE_F00D);
    pushExp(1'b1, 1'b1, 32'd0, 1'b0, t0 + 5);
    step();
    checkOutput("t2_rwi", 32'(mem_rwi), 32'(RWI_WRITE));
    checkOutput("t2_addr", mem_addr, 32'h8000_0004);
    checkOutput("t2_wdata", mem_wdata, 32'hCAFE_F00D);
    checkOutput("t2_grant_d", 32'(grant_d), 32'd1);
    step();
    mem_busy = 1'b1;
    step();
    mem_rdata = 32'hFFFF_0000;
    step();
    mem_busy = 1'b0;
    checkOutput("t2_rwi_wait", 32'(mem_rwi), 32'(RWI_WRITE));
    checkOutput("t2_wdata_wait", mem_wdata, 32'hCAFE_F00D);
    step();
    checkOutput("t2_rwi_done", 32'(mem_rwi), 32'(RWI_IDLE));
    step();
    d_req = 1'b0;
    d_we  = 1'b0;

    // Busy falls in IDLE as the load arrives; only the later fall in WAIT completes it.
    step();
    mem_busy = 1'b1;
    step();
    t0 = cyc;
    mem_busy  = 1'b0;
    mem_rdata = 32'hBAD0_0001;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0200, 32'd0);
    pushExp(1'b1, 1'b0, 32'h55AA_33CC, 1'b0, t0 + 5);
    step();
    mem_busy = 1'b1;
    checkOutput("t6_rwi", 32'(mem_rwi), 32'(RWI_READ));
    step();
    step();
    checkOutput("t6_still_waiting", 32'(mem_rwi), 32'(RWI_READ));
    step();
    mem_busy  = 1'b0;
    mem_rdata = 32'h55AA_33CC;
    step();
    step();
    d_req = 1'b0;

    // Timeout with TIMEOUT_CYCLES=8: WAIT is cycles 2..9, done with err in cycle 10.
    step();
    t0 = cyc;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0300, 32'd0);
    mem_busy = 1'b1;
    pushExp(1'b1, 1'b0, DEADBEEF_WORD, 1'b1, t0 + 10);
    repeat (9) step();
    checkOutput("t4_rwi_c9", 32'(mem_rwi), 32'(RWI_READ));
    step();
    checkOutput("t4_rwi_done", 32'(mem_rwi), 32'(RWI_IDLE));
    step();
    d_req    = 1'b0;
    mem_busy = 1'b0;

    // Reset during WAIT: no done, busy fall after release ignored, next fetch normal.
    step();
    t0 = cyc;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0400, 32'd0);
    mem_busy = 1'b1;
    step();
    step();
    step();
    checkOutput("t5_pre_busy", 32'(arb_busy), 32'd1);
    nrst  = 1'b0;
    d_req = 1'b0;
    #1;
    checkReset("t5");
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    step();
    step();
    nrst = 1'b1;
    step();
    mem_busy = 1'b0;
    checkOutput("t5_idle_a", 32'(arb_busy), 32'd0);
    step();
    checkOutput("t5_idle_b", 32'(arb_busy), 32'd0);
    checkOutput("t5_rwi_idle", 32'(mem_rwi), 32'(RWI_IDLE));
    step();
    t0 = cyc;
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'd0, 32'd0);
    pushExp(1'b0, 1'b0, 32'h7777_1111, 1'b0, t0 + 4);
    step();
    checkOutput("t5_rwi", 32'(mem_rwi), 32'(RWI_FETCH));
    checkOutput("t5_addr", mem_addr, 32'h0000_0500);
    step();
    mem_busy = 1'b1;
    step();
    mem_busy  = 1'b0;
    mem_rdata = 32'h7777_1111;
    step();
    step();
    if_req = 1'b0;

    // Both requests held: grant order D,D,D,D,F,D,D,D,D,F.
    step();
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000, 32'd0);
    for (int n = 0; n < 10; n++) begin
      w = 0;
      while (mem_rwi == RWI_IDLE && w < 8) begin
        step();
        w++;
      end
      checkOutput("burst_issue_seen", 32'(w < 8), 32'd1);
      checkOutput("burst_grant", 32'(mem_rwi), burst_is_d[n] ? 32'(RWI_READ) : 32'(RWI_FETCH));
      checkOutput("burst_grant_d", 32'(grant_d), 32'(burst_is_d[n]));
      pushExp(burst_is_d[n], 1'b0, 32'hA000_0000 + 32'(n), 1'b0, cyc + 2);
      mem_busy  = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(n);
      step();
      mem_busy = 1'b0;
      step();
    end
    step();
    if_req = 1'b0;
    d_req  = 1'b0;

    repeat (4) step();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
